// File: rtl/ap_handshake_profiler.sv
// Per-channel monitor for HLS ap_start/ap_ready/ap_done/ap_continue handshakes with saturating statistics.
// Define HANDSHAKE_STALL_CNT_EN to build the per-channel done-stall counter returned on rd_sel=6.
module ap_handshake_profiler #(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned CNT_W  = 32,
    parameter int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NUM_CH-1:0] ap_start,
    input  logic [NUM_CH-1:0] ap_ready,
    input  logic [NUM_CH-1:0] ap_done,
    input  logic [NUM_CH-1:0] ap_continue,
    input  logic              finish,
    input  logic              clr,
    input  logic [CH_W-1:0]   rd_ch,
    input  logic [2:0]        rd_sel,
    output logic [CNT_W-1:0]  rd_data,
    output logic              frozen
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, WAIT = 2'd2} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             state_q  [NUM_CH];
    logic [CNT_W-1:0]   starts_q [NUM_CH];
    logic [CNT_W-1:0]   dones_q  [NUM_CH];
    logic [CNT_W-1:0]   busy_q   [NUM_CH];
    logic [CNT_W-1:0]   timer_q  [NUM_CH];
    logic [CNT_W-1:0]   last_q   [NUM_CH];
    logic [CNT_W-1:0]   min_q    [NUM_CH];
    logic [CNT_W-1:0]   max_q    [NUM_CH];
`ifdef HANDSHAKE_STALL_CNT_EN
    logic [CNT_W-1:0]   stall_q  [NUM_CH];
`endif
    logic [NUM_CH-1:0]  ovf_q;
    logic [NUM_CH-1:0]  ovl_q;

    logic [NUM_CH-1:0]  cap_en_c;
    logic [CNT_W-1:0]   lat_c    [NUM_CH];
    logic [CNT_W-1:0]   rd_value_c;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    // True when an increment of v lands on (or stays at) the saturation value.
    function automatic logic hits_max(input logic [CNT_W-1:0] v);
        return v >= (CNT_MAX - CNT_W'(1));
    endfunction

    // Latency capture: same-cycle start/done in IDLE is latency 0, otherwise timer+1 from RUN.
    always_comb begin
        cap_en_c = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            lat_c[i] = '0;
            if (state_q[i] == RUN) begin
                cap_en_c[i] = ap_done[i];
                lat_c[i]    = sat_inc(timer_q[i]);
            end else if (state_q[i] == IDLE) begin
                cap_en_c[i] = ap_start[i] & ap_done[i];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset || clr) begin
            frozen <= 1'b0;
            ovf_q  <= '0;
            ovl_q  <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i]  <= IDLE;
                starts_q[i] <= '0;
                dones_q[i]  <= '0;
                busy_q[i]   <= '0;
                timer_q[i]  <= '0;
                last_q[i]   <= '0;
                min_q[i]    <= CNT_MAX;
                max_q[i]    <= '0;
`ifdef HANDSHAKE_STALL_CNT_EN
                stall_q[i]  <= '0;
`endif
            end
        end else if (!frozen) begin
            frozen <= finish;
            for (int i = 0; i < NUM_CH; i++) begin
                if (ap_start[i] && ap_ready[i]) begin
                    starts_q[i] <= sat_inc(starts_q[i]);
                    if (hits_max(starts_q[i])) ovf_q[i] <= 1'b1;
                    if (state_q[i] == RUN) ovl_q[i] <= 1'b1;
                end
                if (ap_done[i] && ap_continue[i]) begin
                    dones_q[i] <= sat_inc(dones_q[i]);
                    if (hits_max(dones_q[i])) ovf_q[i] <= 1'b1;
                end
                if (state_q[i] != IDLE) begin
                    busy_q[i] <= sat_inc(busy_q[i]);
                    if (hits_max(busy_q[i])) ovf_q[i] <= 1'b1;
                end
`ifdef HANDSHAKE_STALL_CNT_EN
                if (ap_done[i] && !ap_continue[i]) begin
                    stall_q[i] <= sat_inc(stall_q[i]);
                    if (hits_max(stall_q[i])) ovf_q[i] <= 1'b1;
                end
`endif
                if (cap_en_c[i]) begin
                    last_q[i] <= lat_c[i];
                    if (lat_c[i] < min_q[i]) min_q[i] <= lat_c[i];
                    if (lat_c[i] > max_q[i]) max_q[i] <= lat_c[i];
                end

                // A start seen in RUN never restarts the timer: latency tracks the oldest start.
                case (state_q[i])
                    IDLE: begin
                        if (ap_start[i]) begin
                            timer_q[i] <= '0;
                            if (!ap_done[i])          state_q[i] <= RUN;
                            else if (!ap_continue[i]) state_q[i] <= WAIT;
                        end
                    end
                    RUN: begin
                        if (ap_done[i]) begin
                            state_q[i] <= ap_continue[i] ? IDLE : WAIT;
                        end else begin
                            timer_q[i] <= sat_inc(timer_q[i]);
                            if (hits_max(timer_q[i])) ovf_q[i] <= 1'b1;
                        end
                    end
                    WAIT: begin
                        if (ap_continue[i]) state_q[i] <= IDLE;
                    end
                    default: state_q[i] <= IDLE;
                endcase
            end
        end
    end

    // Read mux; unmatched channel numbers fall through to zero.
    always_comb begin
        rd_value_c = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_ch == CH_W'(i)) begin
                case (rd_sel)
                    3'd0: rd_value_c = starts_q[i];
                    3'd1: rd_value_c = dones_q[i];
                    3'd2: rd_value_c = busy_q[i];
                    3'd3: rd_value_c = last_q[i];
                    3'd4: rd_value_c = min_q[i];
                    3'd5: rd_value_c = max_q[i];
`ifdef HANDSHAKE_STALL_CNT_EN
                    3'd6: rd_value_c = stall_q[i];
`else
                    3'd6: rd_value_c = '0;
`endif
                    default: rd_value_c[3:0] = {ovl_q[i], ovf_q[i], state_q[i]};
                endcase
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) rd_data <= '0;
        else       rd_data <= rd_value_c;
    end
endmodule

// File: tb/tb_ap_handshake_profiler.sv
// Directed bench for ap_handshake_profiler: 2-channel 32-bit instance plus a 1-channel 4-bit saturation instance.
module tb_ap_handshake_profiler;
`ifdef HANDSHAKE_STALL_CNT_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif
    localparam logic [31:0] ALL1 = 32'hFFFF_FFFF;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  ap_start, ap_ready, ap_done, ap_continue;
    logic        finish, clr, rd_ch, frozen;
    logic [2:0]  rd_sel;
    logic [31:0] rd_data;

    logic        s_start, s_ready, s_done, s_cont, s_finish, s_clr, s_rd_ch, s_frozen;
    logic [2:0]  s_rd_sel;
    logic [3:0]  s_rd_data;

    always #5 clock = ~clock;

    ap_handshake_profiler #(.NUM_CH(2), .CNT_W(32)) dut (
        .clock(clock), .reset(reset), .ap_start(ap_start), .ap_ready(ap_ready),
        .ap_done(ap_done), .ap_continue(ap_continue), .finish(finish), .clr(clr),
        .rd_ch(rd_ch), .rd_sel(rd_sel), .rd_data(rd_data), .frozen(frozen)
    );

    ap_handshake_profiler #(.NUM_CH(1), .CNT_W(4)) sat (
        .clock(clock), .reset(reset), .ap_start(s_start), .ap_ready(s_ready),
        .ap_done(s_done), .ap_continue(s_cont), .finish(s_finish), .clr(s_clr),
        .rd_ch(s_rd_ch), .rd_sel(s_rd_sel), .rd_data(s_rd_data), .frozen(s_frozen)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic rd(input int ch, input int sel, input logic [31:0] exp, input string tag);
        exp_t e;
        rd_ch  = 1'(ch);
        rd_sel = 3'(sel);
        sb.push_back('{tag, exp});
        tick();
        e = sb.pop_front();
        chk(e.tag, rd_data, e.exp);
    endtask

    task automatic rd4(input int ch, input int sel, input logic [31:0] exp, input string tag);
        exp_t e;
        s_rd_ch  = 1'(ch);
        s_rd_sel = 3'(sel);
        sb.push_back('{tag, exp});
        tick();
        e = sb.pop_front();
        chk(e.tag, 32'(s_rd_data), e.exp);
    endtask

    // One transaction with continue held high; lat=0 means start and done in the same cycle.
    task automatic run(input int ch, input int lat);
        ap_start[ch] = 1'b1;
        ap_ready[ch] = 1'b1;
        if (lat == 0) ap_done[ch] = 1'b1;
        tick();
        ap_start[ch] = 1'b0;
        ap_ready[ch] = 1'b0;
        ap_done[ch]  = 1'b0;
        if (lat > 0) begin
            repeat (lat - 1) tick();
            ap_done[ch] = 1'b1;
            tick();
            ap_done[ch] = 1'b0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        ap_start = '0; ap_ready = '0; ap_done = '0; ap_continue = '1;
        finish = 1'b0; clr = 1'b0; rd_ch = 1'b0; rd_sel = '0;
        s_start = 1'b0; s_ready = 1'b0; s_done = 1'b0; s_cont = 1'b1;
        s_finish = 1'b0; s_clr = 1'b0; s_rd_ch = 1'b0; s_rd_sel = '0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;

        chk("rst_rd_data", rd_data, 32'd0);
        chk("rst_frozen", 32'(frozen), 32'd0);
        rd(0, 4, ALL1, "rst_min0");
        rd(1, 7, 32'd0, "rst_stat1");
        rd(0, 0, 32'd0, "rst_starts0");

        // Single run on ch0, latency 7
        run(0, 7);
        rd(0, 0, 32'd1, "t1_starts");
        rd(0, 1, 32'd1, "t1_dones");
        rd(0, 2, 32'd7, "t1_busy");
        rd(0, 3, 32'd7, "t1_last");
        rd(0, 4, 32'd7, "t1_min");
        rd(0, 5, 32'd7, "t1_max");
        rd(0, 7, 32'd0, "t1_stat");
        rd(1, 0, 32'd0, "t1_ch1_starts");

        // Back-to-back latencies on ch1
        run(1, 3);
        run(1, 9);
        run(1, 5);
        rd(1, 3, 32'd5, "t2_last");
        rd(1, 4, 32'd3, "t2_min");
        rd(1, 5, 32'd9, "t2_max");
        rd(1, 0, 32'd3, "t2_starts");
        rd(1, 1, 32'd3, "t2_dones");
        rd(1, 2, 32'd17, "t2_busy");

        // Continue backpressure on ch0: done held 4 cycles with continue low
        ap_start[0] = 1'b1; ap_ready[0] = 1'b1;
        tick();
        ap_start[0] = 1'b0; ap_ready[0] = 1'b0;
        repeat (3) tick();
        ap_done[0] = 1'b1; ap_continue[0] = 1'b0;
        tick();
        rd(0, 7, 32'd2, "t3_wait_state");
        rd(0, 1, 32'd1, "t3_dones_hold");
        tick();
        ap_continue[0] = 1'b1;
        tick();
        ap_done[0] = 1'b0;
        rd(0, 1, 32'd2, "t3_dones");
        rd(0, 6, STALL_EN ? 32'd4 : 32'd0, "t3_stall");
        rd(0, 2, 32'd15, "t3_busy");
        rd(0, 3, 32'd4, "t3_last");
        rd(0, 4, 32'd4, "t3_min");
        rd(0, 5, 32'd7, "t3_max");
        rd(0, 7, 32'd0, "t3_stat");

        // Same-cycle start/done with continue low on ch1: latency 0, then WAIT
        ap_start[1] = 1'b1; ap_ready[1] = 1'b1; ap_done[1] = 1'b1; ap_continue[1] = 1'b0;
        tick();
        ap_start[1] = 1'b0; ap_ready[1] = 1'b0; ap_continue[1] = 1'b1;
        tick();
        ap_done[1] = 1'b0;
        rd(1, 3, 32'd0, "t3b_last");
        rd(1, 4, 32'd0, "t3b_min");
        rd(1, 5, 32'd9, "t3b_max");
        rd(1, 0, 32'd4, "t3b_starts");
        rd(1, 1, 32'd4, "t3b_dones");
        rd(1, 2, 32'd18, "t3b_busy");
        rd(1, 6, STALL_EN ? 32'd1 : 32'd0, "t3b_stall");
        rd(1, 7, 32'd0, "t3b_stat");

        // Pipelined overlap on ch0: second start 2 cycles after the first, done 6 after the first
        ap_start[0] = 1'b1; ap_ready[0] = 1'b1;
        tick();
        ap_start[0] = 1'b0; ap_ready[0] = 1'b0;
        tick();
        ap_start[0] = 1'b1; ap_ready[0] = 1'b1;
        tick();
        ap_start[0] = 1'b0; ap_ready[0] = 1'b0;
        repeat (3) tick();
        ap_done[0] = 1'b1;
        tick();
        ap_done[0] = 1'b0;
        rd(0, 0, 32'd4, "t4_starts");
        rd(0, 1, 32'd3, "t4_dones");
        rd(0, 3, 32'd6, "t4_last");
        rd(0, 4, 32'd4, "t4_min");
        rd(0, 5, 32'd7, "t4_max");
        rd(0, 7, 32'd8, "t4_stat_ovl");
        rd(0, 2, 32'd21, "t4_busy");

        // Freeze: the finish cycle still counts, later activity is ignored
        finish = 1'b1; ap_start[0] = 1'b1; ap_ready[0] = 1'b1;
        tick();
        finish = 1'b0;
        tick();
        ap_start[0] = 1'b0; ap_ready[0] = 1'b0;
        run(1, 3);
        run(1, 3);
        chk("t5_frozen", 32'(frozen), 32'd1);
        rd(0, 0, 32'd5, "t5_starts");
        rd(0, 7, 32'd9, "t5_stat");
        rd(0, 2, 32'd21, "t5_busy");
        rd(1, 0, 32'd4, "t5_ch1_starts");
        rd(1, 2, 32'd18, "t5_ch1_busy");
        rd(1, 3, 32'd0, "t5_ch1_last");
        chk("t5_frozen_late", 32'(frozen), 32'd1);

        // clr wins over finish in the same cycle
        clr = 1'b1; finish = 1'b1;
        tick();
        clr = 1'b0; finish = 1'b0;
        chk("clr_frozen", 32'(frozen), 32'd0);
        rd(0, 4, ALL1, "clr_min");
        rd(0, 0, 32'd0, "clr_starts");
        rd(0, 7, 32'd0, "clr_stat");
        rd(1, 5, 32'd0, "clr_ch1_max");
        rd(1, 6, 32'd0, "clr_ch1_stall");

        // Saturation on the 4-bit instance
        for (int n = 0; n < 20; n++) begin
            s_start = 1'b1; s_ready = 1'b1;
            tick();
            s_start = 1'b0; s_ready = 1'b0; s_done = 1'b1;
            tick();
            s_done = 1'b0;
        end
        rd4(0, 0, 32'd15, "sat_starts");
        rd4(0, 1, 32'd15, "sat_dones");
        rd4(0, 2, 32'd15, "sat_busy");
        rd4(0, 7, 32'd4, "sat_stat_ovf");
        rd4(0, 3, 32'd1, "sat_last");
        rd4(0, 4, 32'd1, "sat_min");
        rd4(1, 0, 32'd0, "sat_rdch_oob");

        // Async reset between edges while ch0 is in RUN and frozen
        ap_start[0] = 1'b1; ap_ready[0] = 1'b1;
        tick();
        ap_start[0] = 1'b0; ap_ready[0] = 1'b0; finish = 1'b1;
        tick();
        finish = 1'b0;
        rd(0, 7, 32'd1, "t7_run_state");
        #3;
        reset = 1'b1;
        #1;
        chk("t7_async_rd_data", rd_data, 32'd0);
        chk("t7_async_frozen", 32'(frozen), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        rd(0, 7, 32'd0, "t7_stat");
        rd(0, 3, 32'd0, "t7_last");
        rd(0, 4, ALL1, "t7_min");
        rd(0, 2, 32'd0, "t7_busy");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
